// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that fills instruction memory and then enables the core
module imem_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        core_enable,
    output logic        load_busy,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [15:0] word_idx;
    logic [7:0]  chk_acc;
    logic [23:0] word_buf;

    logic        accept;
    logic        start_ok;
    logic [15:0] len_full;
    logic        last_byte;
    logic        last_word;

    assign accept    = rx_valid && rx_ready;
    assign len_full  = {rx_data, len_lo};
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (word_idx == len - 16'd1);
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

    assign rx_ready    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                         (state == S_DATA)   || (state == S_CHECK);
    assign load_busy   = rx_ready;
    assign core_enable = (state == S_DONE);
    assign load_error  = (state == S_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok) begin
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    if ({1'b0, len_full} > DEPTH) begin
                        state_nxt = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && last_byte && last_word) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_nxt = (rx_data == chk_acc) ? S_DONE : S_ERROR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bytes enter word_buf from the top, so after three bytes it holds {b2,b1,b0}
    // and the fourth byte completes the little-endian word directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lo       <= 8'd0;
            len          <= 16'd0;
            byte_idx     <= 2'd0;
            word_idx     <= 16'd0;
            chk_acc      <= 8'd0;
            word_buf     <= 24'd0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= 32'd0;
            imem_wr_data <= 32'd0;
            words_loaded <= 16'd0;
        end else begin
            imem_wr_en <= 1'b0;
            if (imem_wr_en) begin
                words_loaded <= words_loaded + 16'd1;
            end
            if (start_ok) begin
                byte_idx     <= 2'd0;
                word_idx     <= 16'd0;
                chk_acc      <= 8'd0;
                words_loaded <= 16'd0;
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: len_lo <= rx_data;
                    S_LEN_HI: len    <= len_full;
                    S_DATA: begin
                        chk_acc  <= chk_acc ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            imem_wr_en   <= 1'b1;
                            imem_wr_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            imem_wr_data <= {rx_data, word_buf};
                            word_idx     <= word_idx + 16'd1;
                        end else begin
                            word_buf <= {rx_data, word_buf[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream writer that fills the core's instruction memory before execution and then releases the core. It accepts a framed byte stream (length, little-endian words, XOR checksum) over a valid/ready handshake and produces one 32-bit write per received word on the instruction-memory write port. It drives the core `enable` input (`core_enable`), so the program counter holds until a load completes successfully.

## Interface
- `ADDR_W`, 10: word-address width of instruction memory; depth = 2^ADDR_W words.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word.
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- `rx_valid` in 1: byte available on `rx_data`.
- `rx_data` in 8: stream byte.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `imem_wr_en` out 1: one-cycle write strobe to instruction memory.
- `imem_wr_addr` out 32: byte address of the write, always word-aligned.
- `imem_wr_data` out 32: assembled word.
- `core_enable` out 1: high only in DONE; drives the core `enable` input.
- `load_busy` out 1: high in LEN_LO, LEN_HI, DATA and CHECK.
- `load_error` out 1: high only in ERROR.
- `words_loaded` out 16: count of words written in the current load.

## Operation
- Frame format: LEN_LO, LEN_HI (word count N, LSB first), then 4·N data bytes (each word LSB first), then CHK = XOR of all 4·N data bytes. CHK is 8'h00 when N = 0.
- Transfer: a byte is accepted in a cycle where `rx_valid && rx_ready`. `rx_ready` is combinational from state only: 1 in LEN_LO, LEN_HI, DATA and CHECK, 0 elsewhere.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
  - IDLE/DONE/ERROR → LEN_LO on `start`. This clears `words_loaded`, the byte index, the word index and the checksum accumulator.
  - LEN_LO → LEN_HI on accept; the byte is stored as len[7:0].
  - LEN_HI → on accept, len[15:8] is stored, then:
    - N > 2^ADDR_W → ERROR, with no writes.
    - N = 0 → CHECK.
    - otherwise → DATA.
  - DATA: each accepted byte shifts into the word at lane `byte_idx` (0..3) and is XORed into the accumulator.
    - On the 4th byte: write strobe is issued, `byte_idx` wraps to 0, word index increments.
    - After word N−1 → CHECK.
  - CHECK → on accept: DONE if `rx_data` equals the accumulator, else ERROR.
  - DONE, ERROR: hold until `start`.
- Write address: BASE_ADDR + 4·word_index, 32-bit wrap-around arithmetic. `words_loaded` increments together with each `imem_wr_en` pulse.
- `start` in LEN_LO, LEN_HI, DATA or CHECK is ignored.
- Words already written are never rolled back: on ERROR, reset or restart, memory keeps them.

## Timing
- Reset values: `rx_ready`=0, `imem_wr_en`=0, `imem_wr_addr`=0, `imem_wr_data`=0, `core_enable`=0, `load_busy`=0, `load_error`=0, `words_loaded`=0, state IDLE.
- Reset mid-operation returns immediately to these values. A new `start` is required.
- `start` sampled at edge k: state is LEN_LO from k, and `rx_ready`=1 in cycle k+1.
- Write latency: the 4th byte of a word is accepted at edge k. `imem_wr_en`, `imem_wr_addr` and `imem_wr_data` are registered and valid in cycle k+1 for exactly one cycle. `words_loaded` updates at edge k+1.
- No backpressure: `rx_ready` stays high during the write cycle. Back-to-back bytes at one per cycle are sustained, giving one write per 4 cycles. Gaps in `rx_valid` never change written values or order.
- The last word's write strobe occurs in the first CHECK cycle. A CHK byte accepted in that same cycle is legal.
- CHK accepted at edge k: `core_enable` (or `load_error`) is 1 from cycle k+1, and `load_busy` is 0 from k+1.
- `start` in DONE: `core_enable` drops in the cycle after `start` is sampled.

## Test plan
- Normal load, ADDR_W=10, stream 02 00 93 00 50 00 13 01 A0 00 71 → two writes: addr 0x0 data 0x00500093, then addr 0x4 data 0x00A00113. `words_loaded`=2, `core_enable`=1, `load_error`=0.
- Same stream with CHK 70 → both writes still occur. ERROR state: `load_error`=1, `core_enable`=0. A `start` followed by the correct stream recovers to DONE.
- Empty program, stream 00 00 00 → no `imem_wr_en` pulses, DONE, `words_loaded`=0.
- Oversize, stream 01 04 (N=1025) → ERROR after the second byte, no writes, `rx_ready`=0 afterwards.
- Pacing, the normal stream driven at one byte per cycle versus with `rx_valid` high one cycle in three → identical write sequence. In the back-to-back run, write strobes are 4 cycles apart.
- Reset mid-load: assert `reset` low after 6 accepted bytes of the normal stream → all outputs return to reset values at once. A later `start` plus the full stream reaches DONE with both writes.
